alu_result_retire: RTL and testbench
====================================

// Module: alu_result_retire
// PURPOSE
//  Retire stage on the consumer side of the ALU: accepts each ALU result (result, jump_now,
//  destination) with a valid/ready handshake and buffers it in a small in-order FIFO.
//  Retires entries in order: drives the register-file write port and, on a taken branch,
//  issues a PC redirect plus a flush of younger buffered work. Sits between EX and fetch/RF.
// PARAMETERS
//  DATA_W     32  width of ALU result / register data
//  RF_ADDR_W  5   register-file address width
//  PC_W       10  instruction address width
//  DEPTH      2   FIFO entries; power of 2, >= 2
//  CNT_W      16  width of retire/flush statistics counters
// PORTS
//  clk              in   1          core clock; all state updates on posedge
//  reset            in   1          synchronous, active-high reset
//  valid_i          in   1          ALU entry present this cycle
//  ready_o          out  1          stage can accept an entry this cycle
//  result_i         in   DATA_W     ALU result_o
//  jump_now_i       in   1          ALU jump_now_o (branch taken)
//  wen_i            in   1          entry writes the register file
//  waddr_i          in   RF_ADDR_W  destination register
//  target_i         in   PC_W       branch target (used only if jump_now_i)
//  rf_wen_o         out  1          register-file write request
//  rf_waddr_o       out  RF_ADDR_W  write address
//  rf_wdata_o       out  DATA_W     write data
//  rf_gnt_i         in   1          RF accepted the write this cycle
//  redirect_o       out  1          one-cycle pulse: fetch must load pc_target_o
//  pc_target_o      out  PC_W       redirect target (valid while redirect_o=1)
//  flush_o          out  1          one-cycle pulse, coincident with redirect_o
//  retired_cnt_o    out  CNT_W      entries retired since reset (saturating)
//  flushed_cnt_o    out  CNT_W      entries discarded by flushes (saturating)
// BEHAVIOUR
//  - Reset: FIFO empty, ptrs/count 0; all outputs 0 except ready_o=1. Reset mid-operation
//    discards every buffered entry; no RF write or redirect is issued in the reset cycle.
//  - Accept: push when valid_i & ready_o. ready_o = (count != DEPTH), registered-state only;
//    no combinational path from rf_gnt_i or valid_i to ready_o.
//  - Latency: entry pushed in cycle N is at the head and visible on outputs in cycle N+1.
//  - Head outputs: rf_waddr_o/rf_wdata_o = head fields (0 when empty);
//    rf_wen_o = head_valid & head.wen. Held stable until retire.
//  - Retire head when head_valid & (~head.wen | rf_gnt_i). rf_gnt_i ignored when rf_wen_o=0.
//  - Taken branch: when retiring head has jump=1 (with wen=1, retire waits for rf_gnt_i),
//    in the retire cycle redirect_o=1, flush_o=1, pc_target_o=head.target; all younger FIFO
//    entries and any entry pushed that same cycle are discarded; count becomes 0 next cycle.
//    Both pulses last exactly one cycle; pc_target_o=0 otherwise.
//  - Simultaneous push+retire (no flush): count unchanged; allowed when full since ready_o
//    derives from pre-retire count (full => no push regardless).
//  - Wrap-around: ptrs are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
//  - Counters: retired_cnt_o += 1 per retire; flushed_cnt_o += number of discarded entries
//    (younger entries + same-cycle push); both saturate at all-ones, never wrap.
//  - Assertions: count never > DEPTH; no push when ~ready_o; redirect_o implies flush_o.
// TESTING
//  1 Reset: hold reset 2 cycles -> ready_o=1, rf_wen_o=0, redirect_o=0, counters=0.
//  2 Push {0x0000_002A,wen=1,waddr=3}, rf_gnt_i=1 -> next cycle rf_wen_o=1,waddr=3,
//    wdata=0x2A; retires that cycle; retired_cnt_o=1.
//  3 rf_gnt_i=0, push 3 entries back-to-back -> ready_o=0 after 2 pushes, 3rd held off;
//    release gnt -> writes emerge in push order, no loss, no duplication.
//  4 Branch entry {jump=1,wen=0,target=0x1F0} at head, younger entry buffered, valid_i=1
//    same cycle -> redirect_o=flush_o=1 one cycle, pc_target_o=0x1F0, flushed_cnt_o+=2.
//  5 Branch with wen=1 and rf_gnt_i=0 for 3 cycles -> no redirect until gnt; then write
//    and redirect in same cycle.
//  6 Assert reset with 2 entries buffered, rf_gnt_i=1 -> no RF write; next cycle empty.

Source files
------------

// File: rtl/alu_result_retire.sv
// Retire stage behind the ALU. Buffers ALU results in a small in-order FIFO and
// retires them to the register-file write port. A taken branch at the head
// issues a one-cycle PC redirect and flushes everything younger.
module alu_result_retire #(
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 5,
    parameter int PC_W      = 10,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DATA_W-1:0]    result_i,
    input  logic                 jump_now_i,
    input  logic                 wen_i,
    input  logic [RF_ADDR_W-1:0] waddr_i,
    input  logic [PC_W-1:0]      target_i,
    output logic                 rf_wen_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0]    rf_wdata_o,
    input  logic                 rf_gnt_i,
    output logic                 redirect_o,
    output logic [PC_W-1:0]      pc_target_o,
    output logic                 flush_o,
    output logic [CNT_W-1:0]     retired_cnt_o,
    output logic [CNT_W-1:0]     flushed_cnt_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_FW-1:0] FULL_COUNT = CNT_FW'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0]    result;
        logic                 jump;
        logic                 wen;
        logic [RF_ADDR_W-1:0] waddr;
        logic [PC_W-1:0]      target;
    } entry_t;

    entry_t              fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_FW-1:0]   count;
    logic [CNT_W-1:0]    retired_cnt;
    logic [CNT_W-1:0]    flushed_cnt;

    entry_t              in_entry;
    entry_t              head;
    logic                head_valid;
    logic                push;
    logic                retire;
    logic                flush;
    logic [CNT_FW-1:0]   discard_num;

    // Saturating add for the statistics counters: sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0]  a,
                                                 input logic [CNT_FW-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // ready_o depends on registered count only, so no path from valid_i or rf_gnt_i.
    assign ready_o = (count != FULL_COUNT);

    // Handshake and retire decisions; everything is suppressed in the reset cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        in_entry        = '0;
        in_entry.result = result_i;
        in_entry.jump   = jump_now_i;
        in_entry.wen    = wen_i;
        in_entry.waddr  = waddr_i;
        in_entry.target = target_i;
        head            = fifo_mem[rd_ptr];
        head_valid      = (count != '0);
        push            = valid_i & ready_o;
        retire          = ~reset & head_valid & (~head.wen | rf_gnt_i);
        flush           = retire & head.jump;
        discard_num     = '0;
        if (flush) begin
            // Younger buffered entries plus a push landing in the same cycle.
            discard_num = count - CNT_FW'(1) + CNT_FW'(push);
        end
    end

    // Head-of-FIFO outputs toward the register file and fetch.
    always_comb begin
        rf_wen_o    = 1'b0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        redirect_o  = flush;
        flush_o     = flush;
        pc_target_o = '0;
        if (~reset && head_valid) begin
            rf_wen_o   = head.wen;
            rf_waddr_o = head.waddr;
            rf_wdata_o = head.result;
        end
        if (flush) begin
            pc_target_o = head.target;
        end
    end

    // Entry storage: written on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count alone decide what is valid.
        if (push) begin
            fifo_mem[wr_ptr] <= in_entry;
        end
    end

    // Pointer, occupancy and statistics state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            retired_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (retire) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_FW'(push) - CNT_FW'(retire);
            end
            if (retire) begin
                retired_cnt <= sat_add(retired_cnt, CNT_FW'(1));
            end
            if (flush) begin
                flushed_cnt <= sat_add(flushed_cnt, discard_num);
            end
        end
    end

    assign retired_cnt_o = retired_cnt;
    assign flushed_cnt_o = flushed_cnt;

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= FULL_COUNT);
    a_push_ready: assert property (@(posedge clk) disable iff (reset)
        push |-> (count != FULL_COUNT));
    a_redirect_flush: assert property (@(posedge clk)
        redirect_o |-> flush_o);

endmodule

// File: tb/tb_alu_result_retire.sv
// Bench for alu_result_retire: directed scenarios plus a short random stream,
// checked every cycle against a queue-based reference of the buffered entries.
module tb_alu_result_retire;

    localparam int DATA_W    = 32;
    localparam int RF_ADDR_W = 5;
    localparam int PC_W      = 10;
    localparam int DEPTH     = 2;
    localparam int CNT_W     = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid_i;
    logic                 ready_o;
    logic [DATA_W-1:0]    result_i;
    logic                 jump_now_i;
    logic                 wen_i;
    logic [RF_ADDR_W-1:0] waddr_i;
    logic [PC_W-1:0]      target_i;
    logic                 rf_wen_o;
    logic [RF_ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0]    rf_wdata_o;
    logic                 rf_gnt_i;
    logic                 redirect_o;
    logic [PC_W-1:0]      pc_target_o;
    logic                 flush_o;
    logic [CNT_W-1:0]     retired_cnt_o;
    logic [CNT_W-1:0]     flushed_cnt_o;

    typedef struct {
        logic [DATA_W-1:0]    result;
        logic                 jump;
        logic                 wen;
        logic [RF_ADDR_W-1:0] waddr;
        logic [PC_W-1:0]      target;
    } ent_t;

    ent_t             sb_q[$];
    logic [CNT_W-1:0] m_ret;
    logic [CNT_W-1:0] m_fl;
    int               checks   = 0;
    int               failures = 0;

    alu_result_retire #(
        .DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .result_i(result_i), .jump_now_i(jump_now_i), .wen_i(wen_i), .waddr_i(waddr_i),
        .target_i(target_i), .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .rf_gnt_i(rf_gnt_i), .redirect_o(redirect_o),
        .pc_target_o(pc_target_o), .flush_o(flush_o),
        .retired_cnt_o(retired_cnt_o), .flushed_cnt_o(flushed_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        return (s > (2**CNT_W - 1)) ? '1 : CNT_W'(s);
    endfunction

    task automatic drive(input logic v, input logic [DATA_W-1:0] res, input logic j,
                         input logic w, input logic [RF_ADDR_W-1:0] wa,
                         input logic [PC_W-1:0] tgt);
        valid_i    = v;
        result_i   = res;
        jump_now_i = j;
        wen_i      = w;
        waddr_i    = wa;
        target_i   = tgt;
    endtask

    // One clock: compare outputs against the reference, then advance it at the edge.
    task automatic cycle();
        int   sz;
        logic m_ready, m_push, m_retire, m_flush;
        ent_t h;
        ent_t nw;
        #1;
        if (reset) begin
            check("rst_rf_wen", 64'(rf_wen_o), 64'(0));
            check("rst_redirect", 64'(redirect_o), 64'(0));
            check("rst_flush", 64'(flush_o), 64'(0));
            @(posedge clk);
            sb_q.delete();
            m_ret = '0;
            m_fl  = '0;
            @(negedge clk);
            return;
        end
        sz      = sb_q.size();
        m_ready = (sz != DEPTH);
        h       = '{default: '0};
        check("ready", 64'(ready_o), 64'(m_ready));
        check("retired_cnt", 64'(retired_cnt_o), 64'(m_ret));
        check("flushed_cnt", 64'(flushed_cnt_o), 64'(m_fl));
        if (sz > 0) h = sb_q[0];
        check("rf_wen", 64'(rf_wen_o), 64'((sz > 0) && h.wen));
        check("rf_waddr", 64'(rf_waddr_o), 64'(h.waddr));
        check("rf_wdata", 64'(rf_wdata_o), 64'(h.result));
        m_retire = (sz > 0) && (!h.wen || rf_gnt_i);
        m_flush  = m_retire && h.jump;
        check("redirect", 64'(redirect_o), 64'(m_flush));
        check("flush", 64'(flush_o), 64'(m_flush));
        check("pc_target", 64'(pc_target_o), 64'(m_flush ? h.target : '0));
        m_push = valid_i && m_ready;
        nw = '{result: result_i, jump: jump_now_i, wen: wen_i, waddr: waddr_i, target: target_i};
        @(posedge clk);
        if (m_retire) m_ret = sat_inc(m_ret, 1);
        if (m_flush) begin
            m_fl = sat_inc(m_fl, (sz - 1) + int'(m_push));
            sb_q.delete();
        end else begin
            if (m_retire) void'(sb_q.pop_front());
            if (m_push) sb_q.push_back(nw);
        end
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        rf_gnt_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Reset held two cycles, then idle state.
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("t1_ready", 64'(ready_o), 64'(1));
        check("t1_rf_wen", 64'(rf_wen_o), 64'(0));
        check("t1_redirect", 64'(redirect_o), 64'(0));
        check("t1_retired", 64'(retired_cnt_o), 64'(0));
        check("t1_flushed", 64'(flushed_cnt_o), 64'(0));
        cycle();

        // Single write with grant: visible the next cycle and retired there.
        rf_gnt_i = 1'b1;
        drive(1'b1, 32'h0000_002A, 1'b0, 1'b1, 5'd3, '0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        check("t2_rf_wen", 64'(rf_wen_o), 64'(1));
        check("t2_waddr", 64'(rf_waddr_o), 64'(3));
        check("t2_wdata", 64'(rf_wdata_o), 64'h2A);
        cycle();
        cycle();
        check("t2_retired", 64'(retired_cnt_o), 64'(1));

        // Back-pressure: grant withheld, third push held off until space frees.
        rf_gnt_i = 1'b0;
        drive(1'b1, 32'h1111_0001, 1'b0, 1'b1, 5'd10, '0);
        cycle();
        drive(1'b1, 32'h2222_0002, 1'b0, 1'b1, 5'd11, '0);
        cycle();
        drive(1'b1, 32'h3333_0003, 1'b0, 1'b1, 5'd12, '0);
        #1;
        check("t3_full_ready", 64'(ready_o), 64'(0));
        cycle();
        cycle();
        rf_gnt_i = 1'b1;
        cycle();
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        cycle();
        check("t3_retired", 64'(retired_cnt_o), 64'(4));

        // Writing branch stalled on grant, younger entry buffered, blocked push pending.
        rf_gnt_i = 1'b0;
        drive(1'b1, 32'h0000_0077, 1'b1, 1'b1, 5'd7, 10'h155);
        cycle();
        drive(1'b1, 32'h0000_0088, 1'b0, 1'b1, 5'd8, '0);
        cycle();
        drive(1'b1, 32'h0000_0099, 1'b0, 1'b1, 5'd9, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_no_redirect", 64'(redirect_o), 64'(0));
            cycle();
        end
        rf_gnt_i = 1'b1;
        #1;
        check("t5_redirect", 64'(redirect_o), 64'(1));
        check("t5_rf_wen", 64'(rf_wen_o), 64'(1));
        check("t5_target", 64'(pc_target_o), 64'h155);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        check("t5_flushed", 64'(flushed_cnt_o), 64'(1));

        // Non-writing branch at head with a same-cycle push that must be discarded.
        drive(1'b1, 32'h0000_0055, 1'b1, 1'b0, 5'd1, 10'h1F0);
        cycle();
        drive(1'b1, 32'h0000_0066, 1'b0, 1'b1, 5'd2, '0);
        #1;
        check("t4_redirect", 64'(redirect_o), 64'(1));
        check("t4_flush", 64'(flush_o), 64'(1));
        check("t4_target", 64'(pc_target_o), 64'h1F0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        check("t4_pulse_end", 64'(redirect_o), 64'(0));
        check("t4_empty", 64'(rf_wen_o), 64'(0));
        cycle();
        check("t4_flushed", 64'(flushed_cnt_o), 64'(2));

        // Random traffic exercising wrap-around and simultaneous push/retire.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), RF_ADDR_W'($urandom), PC_W'($urandom));
            rf_gnt_i = 1'($urandom_range(0, 1));
            cycle();
        end

        // Reset with two entries buffered and grant high: nothing written.
        rf_gnt_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        cycle();
        cycle();
        cycle();
        drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b1, 5'd20, '0);
        cycle();
        drive(1'b1, 32'hAAAA_0002, 1'b0, 1'b1, 5'd21, '0);
        cycle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        reset    = 1'b1;
        rf_gnt_i = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("t6_rf_wen", 64'(rf_wen_o), 64'(0));
        check("t6_ready", 64'(ready_o), 64'(1));
        check("t6_retired", 64'(retired_cnt_o), 64'(0));
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
